// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the loader/debug port, the instruction
// memory array and the arbiter. The arbiter takes the slave view; the
// requesters and memory together take the master view.
interface imem_port_arbiter_if #(
    parameter int unsigned MEM_DEPTH_LOG2 = 10
);
    logic                      fetch_req;
    logic [31:0]               fetch_addr;
    logic                      fetch_gnt;
    logic                      fetch_rvalid;
    logic [31:0]               fetch_rdata;

    logic                      load_req;
    logic                      load_we;
    logic [31:0]               load_addr;
    logic [31:0]               load_wdata;
    logic                      load_gnt;
    logic                      load_rvalid;
    logic [31:0]               load_rdata;

    logic                      mem_en;
    logic                      mem_we;
    logic [MEM_DEPTH_LOG2-1:0] mem_addr;
    logic [31:0]               mem_wdata;
    logic [31:0]               mem_rdata;

    logic                      addr_err;

    modport slave (
        input  fetch_req, fetch_addr,
        input  load_req, load_we, load_addr, load_wdata,
        input  mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output load_gnt, load_rvalid, load_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output addr_err
    );

    modport master (
        output fetch_req, fetch_addr,
        output load_req, load_we, load_addr, load_wdata,
        output mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  load_gnt, load_rvalid, load_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  addr_err
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter: shares one single-port memory between the
// read-only fetch unit and a read/write loader port. The loader has priority,
// and a starvation counter forces a fetch grant after STARVE_LIMIT denials.
module imem_port_arbiter #(
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter logic [31:0] NOP_INSN       = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    imem_port_arbiter_if.slave  bus
);
    localparam logic [3:0]  LIMIT  = 4'(STARVE_LIMIT);
    localparam int unsigned HI_LSB = MEM_DEPTH_LOG2 + 2;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_FETCH,
        RD_LOAD,
        RD_OOR_FETCH,
        RD_OOR_LOAD
    } rd_owner_t;

    rd_owner_t   rd_owner;
    rd_owner_t   rd_owner_d;
    logic [3:0]  starve_cnt;
    logic        fetch_rvalid;
    logic        load_rvalid;
    logic [31:0] fetch_hold;
    logic [31:0] load_hold;
    logic        addr_err;

    logic        force_fetch;
    logic        fetch_gnt;
    logic        load_gnt;
    logic        any_gnt;
    logic [31:0] gnt_addr;
    logic        gnt_oor;
    logic        gnt_misaligned;
    logic [31:0] fetch_rdata_c;
    logic [31:0] load_rdata_c;

    // Same-cycle grant decision and address classification of the winner.
    always_comb begin
        force_fetch    = bus.fetch_req & (starve_cnt == LIMIT);
        fetch_gnt      = bus.fetch_req & (~bus.load_req | force_fetch);
        load_gnt       = bus.load_req & ~fetch_gnt;
        any_gnt        = fetch_gnt | load_gnt;
        gnt_addr       = fetch_gnt ? bus.fetch_addr : bus.load_addr;
        gnt_oor        = (gnt_addr >> HI_LSB) != '0;
        gnt_misaligned = gnt_addr[1:0] != 2'b00;
    end

    // Owner of the read accepted this cycle; writes leave it at NONE.
    always_comb begin
        rd_owner_d = RD_NONE;
        if (fetch_gnt) begin
            rd_owner_d = gnt_oor ? RD_OOR_FETCH : RD_FETCH;
        end else if (load_gnt && !bus.load_we) begin
            rd_owner_d = gnt_oor ? RD_OOR_LOAD : RD_LOAD;
        end
    end

    // Read data arrives from memory during the cycle after the strobe, so the
    // returned word is muxed straight through while rvalid is high and then
    // captured into a hold register so rdata stays put between responses.
    always_comb begin
        fetch_rdata_c = (rd_owner == RD_OOR_FETCH) ? NOP_INSN : bus.mem_rdata;
        load_rdata_c  = (rd_owner == RD_OOR_LOAD)  ? NOP_INSN : bus.mem_rdata;
    end

    // Read-return FSM, rvalid/rdata hold, starvation counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner     <= RD_NONE;
            fetch_rvalid <= 1'b0;
            load_rvalid  <= 1'b0;
            fetch_hold   <= '0;
            load_hold    <= '0;
            starve_cnt   <= '0;
            addr_err     <= 1'b0;
        end else begin
            rd_owner     <= rd_owner_d;
            fetch_rvalid <= (rd_owner_d == RD_FETCH) || (rd_owner_d == RD_OOR_FETCH);
            load_rvalid  <= (rd_owner_d == RD_LOAD)  || (rd_owner_d == RD_OOR_LOAD);
            if (fetch_rvalid) begin
                fetch_hold <= fetch_rdata_c;
            end
            if (load_rvalid) begin
                load_hold <= load_rdata_c;
            end
            if (bus.fetch_req && !fetch_gnt) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
            if (any_gnt && (gnt_oor || gnt_misaligned)) begin
                addr_err <= 1'b1;
            end
        end
    end

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.load_gnt     = load_gnt;
    assign bus.mem_en       = any_gnt & ~gnt_oor;
    assign bus.mem_we       = load_gnt & bus.load_we;
    assign bus.mem_addr     = gnt_addr[MEM_DEPTH_LOG2+1:2];
    assign bus.mem_wdata    = bus.load_wdata;
    assign bus.fetch_rvalid = fetch_rvalid;
    assign bus.load_rvalid  = load_rvalid;
    assign bus.fetch_rdata  = fetch_rvalid ? fetch_rdata_c : fetch_hold;
    assign bus.load_rdata   = load_rvalid  ? load_rdata_c  : load_hold;
    assign bus.addr_err     = addr_err;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters against a behavioural model.
module tb_imem_port_arbiter;
    localparam int unsigned DL    = 10;
    localparam int unsigned DEPTH = 1 << DL;
    localparam int unsigned LIMIT = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.MEM_DEPTH_LOG2(DL)) bus ();

    imem_port_arbiter #(
        .MEM_DEPTH_LOG2(DL),
        .STARVE_LIMIT(LIMIT),
        .NOP_INSN(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Environment memory: synchronous single-port array driven by the DUT.
    logic [31:0] env_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= env_mem[bus.mem_addr];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    int          denied_run;
    bit          pend_v;
    bit          pend_is_load;
    logic [31:0] pend_d;
    logic [31:0] last_f, last_l;
    bit          err_seen;
    bit          exp_fg, exp_lg;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        denied_run = 0;
        pend_v     = 1'b0;
        last_f     = '0;
        last_l     = '0;
        err_seen   = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // then advance the model to what the next cycle must look like.
    task automatic step(input bit fr, input logic [31:0] fa, input bit lr,
                        input bit lw, input logic [31:0] la, input logic [31:0] ld);
        logic [31:0] ga;
        bit          oor, mis, rd_exp_fv, rd_exp_lv;
        logic [31:0] exp_fd, exp_ld;
        int unsigned idx;
        @(negedge clk);
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.load_req   = lr;
        bus.load_we    = lw;
        bus.load_addr  = la;
        bus.load_wdata = ld;
        #1;
        exp_fg = fr && (!lr || denied_run >= int'(LIMIT));
        exp_lg = lr && !exp_fg;
        ga  = exp_fg ? fa : la;
        oor = ga >= 32'(DEPTH * 4);
        mis = (ga % 4) != 0;
        idx = (ga / 4) % DEPTH;

        rd_exp_fv = pend_v && !pend_is_load;
        rd_exp_lv = pend_v && pend_is_load;
        if (rd_exp_fv) last_f = pend_d;
        if (rd_exp_lv) last_l = pend_d;
        exp_fd = last_f;
        exp_ld = last_l;

        chk("fetch_gnt", 32'(bus.fetch_gnt), 32'(exp_fg));
        chk("load_gnt",  32'(bus.load_gnt),  32'(exp_lg));
        chk("mem_en",    32'(bus.mem_en),    32'((exp_fg || exp_lg) && !oor));
        chk("mem_we",    32'(bus.mem_we),    32'(exp_lg && lw));
        chk("mem_wdata", bus.mem_wdata, ld);
        if (exp_fg || exp_lg) chk("mem_addr", 32'(bus.mem_addr), 32'(idx));
        chk("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(rd_exp_fv));
        chk("load_rvalid",  32'(bus.load_rvalid),  32'(rd_exp_lv));
        chk("fetch_rdata",  bus.fetch_rdata, exp_fd);
        chk("load_rdata",   bus.load_rdata,  exp_ld);
        chk("addr_err",     32'(bus.addr_err), 32'(err_seen));

        pend_v       = exp_fg || (exp_lg && !lw);
        pend_is_load = !exp_fg;
        pend_d       = oor ? NOP : ref_mem[idx];
        if (exp_lg && lw && !oor) ref_mem[idx] = ld;
        if (fr && !exp_fg) denied_run = (denied_run < int'(LIMIT)) ? denied_run + 1 : denied_run;
        else               denied_run = 0;
        if ((exp_fg || exp_lg) && (oor || mis)) err_seen = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        bus.load_we   = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_fetch_rvalid", 32'(bus.fetch_rvalid), 32'h0);
        chk("rst_load_rvalid",  32'(bus.load_rvalid),  32'h0);
        chk("rst_fetch_rdata",  bus.fetch_rdata, 32'h0);
        chk("rst_load_rdata",   bus.load_rdata,  32'h0);
        chk("rst_addr_err",     32'(bus.addr_err), 32'h0);
        chk("rst_mem_en",       32'(bus.mem_en), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_hold_fetch_rvalid", 32'(bus.fetch_rvalid), 32'h0);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 31);
        if (r == 0)      return 32'h0000_1000 | ($urandom & 32'hFFFF_FFFC);
        else if (r == 1) return ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
        else             return $urandom_range(0, 63) * 4;
    endfunction

    initial begin
        bit          f_on, l_on, l_we;
        logic [31:0] f_addr, l_addr, l_wd;

        for (int i = 0; i < int'(DEPTH); i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[0] = 32'h1111_1111; ref_mem[0] = 32'h1111_1111;
        env_mem[1] = 32'h2222_2222; ref_mem[1] = 32'h2222_2222;
        env_mem[2] = 32'h3333_3333; ref_mem[2] = 32'h3333_3333;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.load_req  = 1'b0; bus.load_we = 1'b0;
        bus.load_addr = '0;   bus.load_wdata = '0;
        model_reset();

        // Power-on reset state.
        do_reset();

        // Fetch-only stream 0x0, 0x4, 0x8.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_fetch_gnt0", 32'(bus.fetch_gnt), 32'h1);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_fetch_d0", bus.fetch_rdata, 32'h1111_1111);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_fetch_d1", bus.fetch_rdata, 32'h2222_2222);
        idle();
        chk("lit_fetch_d2", bus.fetch_rdata, 32'h3333_3333);
        idle();
        chk("lit_rdata_hold", bus.fetch_rdata, 32'h3333_3333);

        // Loader write then fetch of the same word.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hAAAA_AAAA);
        chk("lit_wr_we",   32'(bus.mem_we), 32'h1);
        chk("lit_wr_addr", 32'(bus.mem_addr), 32'h4);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk("lit_wr_readback", bus.fetch_rdata, 32'hAAAA_AAAA);

        // Contention: loader wins four cycles, fetch forced on the fifth.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0);
            chk("lit_starve_lgnt", 32'(bus.load_gnt), 32'((i % 5) != 4));
        end
        idle();

        // Out-of-range fetch returns NOP and sets the sticky error.
        step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_oor_mem_en", 32'(bus.mem_en), 32'h0);
        idle();
        chk("lit_oor_rvalid", 32'(bus.fetch_rvalid), 32'h1);
        chk("lit_oor_rdata",  bus.fetch_rdata, 32'h0000_0013);
        chk("lit_oor_err",    32'(bus.addr_err), 32'h1);
        idle();
        chk("lit_err_sticky", 32'(bus.addr_err), 32'h1);

        // Misaligned loader read at 0x6.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0);
        chk("lit_mis_addr", 32'(bus.mem_addr), 32'h1);
        idle();
        chk("lit_mis_rvalid", 32'(bus.load_rvalid), 32'h1);
        chk("lit_mis_rdata",  bus.load_rdata, 32'h2222_2222);
        chk("lit_mis_err",    32'(bus.addr_err), 32'h1);

        // Reset with a fetch read in flight: no stray rvalid after release.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();
        repeat (3) begin
            idle();
            chk("lit_no_stray", 32'(bus.fetch_rvalid), 32'h0);
        end

        // Randomized requesters that hold their request until granted.
        f_on = 1'b0; l_on = 1'b0;
        f_addr = '0; l_addr = '0; l_wd = '0; l_we = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!f_on) begin
                f_on   = $urandom_range(0, 3) != 0;
                f_addr = rand_addr();
            end
            if (!l_on) begin
                l_on   = $urandom_range(0, 2) == 0;
                l_we   = $urandom_range(0, 1) == 1;
                l_addr = rand_addr();
                l_wd   = $urandom;
            end
            step(f_on, f_addr, l_on, l_we, l_addr, l_wd);
            if (exp_fg) f_on = 1'b0;
            if (exp_lg) l_on = 1'b0;
            if (n == 1500) begin
                do_reset();
                f_on = 1'b0; l_on = 1'b0;
            end
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction memory between the fetch unit (read-only) and a program loader/debug port (read/write).
- Lets programs be written into instruction memory through ports instead of hierarchical testbench pokes.
- Sits between the instruction fetch unit and the instruction memory array inside riscv_processor.
- Load port has priority; a starvation counter guarantees fetch progress.

Parameters:
- MEM_DEPTH_LOG2, 10, log2 of memory depth in 32-bit words.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced a grant; legal range 1..15.
- NOP_INSN, 32'h00000013, data returned for out-of-range reads.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch read request.
- fetch_addr  in  32  fetch byte address.
- fetch_gnt  out  1  fetch request accepted this cycle; low means stall the PC.
- fetch_rvalid  out  1  fetch_rdata is valid.
- fetch_rdata  out  32  fetched instruction.
- load_req  in  1  loader request.
- load_we  in  1  1 = write, 0 = read.
- load_addr  in  32  loader byte address.
- load_wdata  in  32  loader write data.
- load_gnt  out  1  loader request accepted this cycle.
- load_rvalid  out  1  load_rdata is valid.
- load_rdata  out  32  loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_DEPTH_LOG2  word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  read data, valid one cycle after a read strobe.
- addr_err  out  1  sticky: a misaligned or out-of-range request was accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs go to 0: fetch_rvalid, load_rvalid, fetch_rdata, load_rdata, addr_err.
  - starve_cnt=0, rd_owner=NONE.
  - Combinational outputs follow the inputs with the counter at 0.
- Grant decision is combinational, in the same cycle as the request:
  - force_fetch = fetch_req & (starve_cnt == STARVE_LIMIT).
  - fetch_gnt = fetch_req & (~load_req | force_fetch).
  - load_gnt = load_req & ~fetch_gnt.
  - At most one grant per cycle.
- Memory drive:
  - mem_en = fetch_gnt | load_gnt, suppressed for out-of-range accesses.
  - mem_we = load_gnt & load_we.
  - mem_addr = granted addr[MEM_DEPTH_LOG2+1:2].
  - mem_wdata = load_wdata.
- Address checks on the granted request:
  - Misaligned (addr[1:0] != 0): access proceeds on the truncated word index, addr_err is set.
  - Out of range (addr[31:MEM_DEPTH_LOG2+2] != 0): no memory strobe, addr_err is set. A read returns NOP_INSN; a write is dropped.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle fetch_req=1 and fetch_gnt=0.
  - Clears to 0 on any fetch_gnt or any cycle with fetch_req=0.
- Read return state machine (rd_owner): NONE / FETCH / LOAD / OOR_FETCH / OOR_LOAD.
  - Each cycle rd_owner is loaded with the owner of the read accepted that cycle, or NONE.
  - Writes do not load rd_owner.
  - Cycle after a FETCH read: fetch_rvalid=1, fetch_rdata=mem_rdata, registered into the output.
  - OOR owner states return NOP_INSN instead of mem_rdata.
  - Latency: grant at cycle N, rvalid at cycle N+1, 1-cycle pulse.
  - Back-to-back reads from either port are supported every cycle.
  - rdata holds its last value when rvalid=0.
- Simultaneous requests: load wins unless force_fetch, in which case load_gnt=0 and the loader must hold its request.
- Requesters hold req/addr/wdata stable until granted.
- Reset asserted with a read in flight: rvalid is not produced after reset releases.
- addr_err clears only on reset.

Test Plan:
- Fetch only: fetch_req=1 with addresses 0x0, 0x4, 0x8 on consecutive cycles, memory preloaded with 0x11111111/0x22222222/0x33333333 -> fetch_gnt=1 every cycle; fetch_rvalid from the following cycle with the matching data in order.
- Loader write then fetch: load writes 0xAAAAAAAA to 0x10 while fetch_req=0, then fetch reads 0x10 -> mem_we=1, mem_addr=4; fetch_rdata=0xAAAAAAAA one cycle after its grant.
- Contention/starvation (STARVE_LIMIT=4): load_req and fetch_req held high -> load_gnt for 4 cycles, fetch_gnt on the 5th cycle, then load again; the pattern repeats every 5 cycles.
- Out of range: fetch_addr=0x00001000 with MEM_DEPTH_LOG2=10 -> mem_en=0, fetch_rvalid next cycle with fetch_rdata=0x00000013, addr_err=1 and sticky.
- Misaligned load read at 0x6 -> mem_addr=1, load_rvalid next cycle, addr_err=1.
- Reset mid-read: assert reset=0 the cycle after a fetch grant -> fetch_rvalid stays 0, all outputs reset, no stray rvalid after release.
